// File: rtl/id_hazard_stall_ctrl.sv
// ID-stage hazard controller: detects load-use and branch-operand hazards the ID
// forwarding paths cannot cover, sequences stalls/bubbles, flushes on taken branches.
module id_hazard_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_is_branch,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic             RegWriteEn_IDEX,
    input  logic             MemRead_IDEX,
    input  logic [4:0]       writeRegister_IDEX,
    input  logic             RegWriteEn_EXMEM,
    input  logic             MemRead_EXMEM,
    input  logic [4:0]       writeRegister_EXMEM,
    input  logic             branch_taken,
    input  logic             ext_hold,
    output logic             stall_PC,
    output logic             stall_IFID,
    output logic             bubble_IDEX,
    output logic             flush_IFID,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             busy
);

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

    state_t            state_q, state_d;
    logic              cnt_q, cnt_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;

    logic              m_ex, m_mem;
    logic [1:0]        need;
    logic              hold_int, bubble_int, flush_int;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Register $0 never creates a dependency.
    always_comb begin
        m_ex  = RegWriteEn_IDEX && (writeRegister_IDEX != 5'd0) &&
                (((writeRegister_IDEX == rs) && id_uses_rs) ||
                 ((writeRegister_IDEX == rt) && id_uses_rt));
        m_mem = RegWriteEn_EXMEM && (writeRegister_EXMEM != 5'd0) &&
                (((writeRegister_EXMEM == rs) && id_uses_rs) ||
                 ((writeRegister_EXMEM == rt) && id_uses_rt));
    end

    always_comb begin
        need = 2'd0;
        if (id_valid) begin
            if (m_ex && MemRead_IDEX && id_is_branch)           need = 2'd2;
            else if (m_ex && MemRead_IDEX)                      need = 2'd1;
            else if (id_is_branch && m_ex)                      need = 2'd1;
            else if (id_is_branch && m_mem && MemRead_EXMEM)    need = 2'd1;
            else                                                need = 2'd0;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_int   = 1'b0;
        bubble_int = 1'b0;
        flush_int  = 1'b0;
        if (ext_hold) begin
            hold_int = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (need != 2'd0) begin
                        hold_int   = 1'b1;
                        bubble_int = 1'b1;
                        if (need == 2'd2) begin
                            state_d = STALL;
                            cnt_d   = 1'b0;
                        end
                    end else if (id_valid && id_is_branch && branch_taken) begin
                        flush_int = 1'b1;
                    end
                end
                STALL: begin
                    hold_int   = 1'b1;
                    bubble_int = 1'b1;
                    if (cnt_q == 1'b0) state_d = RUN;
                    else               cnt_d   = cnt_q - 1'b1;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (bubble_int && (stall_cycles_q != CNT_MAX)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
        if (flush_int && (flush_count_q != CNT_MAX))   flush_count_d  = flush_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            cnt_q          <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    // Gate the combinational controls so nothing leaks out while reset is held.
    assign stall_PC     = rst_n & hold_int;
    assign stall_IFID   = rst_n & hold_int;
    assign bubble_IDEX  = rst_n & bubble_int;
    assign flush_IFID   = rst_n & flush_int;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
    assign busy         = (state_q == STALL);

endmodule

// File: tb/tb_id_hazard_stall_ctrl.sv
// Directed bench for id_hazard_stall_ctrl with a remaining-stall-count reference model.
module tb_id_hazard_stall_ctrl;

    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid, id_is_branch, id_uses_rs, id_uses_rt;
    logic [4:0] rs, rt;
    logic RegWriteEn_IDEX, MemRead_IDEX;
    logic [4:0] writeRegister_IDEX;
    logic RegWriteEn_EXMEM, MemRead_EXMEM;
    logic [4:0] writeRegister_EXMEM;
    logic branch_taken, ext_hold;
    logic stall_PC, stall_IFID, bubble_IDEX, flush_IFID, busy;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int errors = 0;
    int checks = 0;

    id_hazard_stall_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_is_branch(id_is_branch),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .rs(rs), .rt(rt),
        .RegWriteEn_IDEX(RegWriteEn_IDEX), .MemRead_IDEX(MemRead_IDEX),
        .writeRegister_IDEX(writeRegister_IDEX),
        .RegWriteEn_EXMEM(RegWriteEn_EXMEM), .MemRead_EXMEM(MemRead_EXMEM),
        .writeRegister_EXMEM(writeRegister_EXMEM),
        .branch_taken(branch_taken), .ext_hold(ext_hold),
        .stall_PC(stall_PC), .stall_IFID(stall_IFID), .bubble_IDEX(bubble_IDEX),
        .flush_IFID(flush_IFID), .stall_cycles(stall_cycles),
        .flush_count(flush_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model state: stall cycles still owed after the current one, and the counters.
    int m_rem = 0;
    int m_sc  = 0;
    int m_fc  = 0;

    typedef struct packed {
        logic hold;
        logic bub;
        logic fl;
        logic bsy;
    } exp_t;

    function automatic int model_need();
        bit reads5[int];
        bit ex_hit, mem_hit;
        if (!id_valid) return 0;
        if (id_uses_rs && rs != 0) reads5[rs] = 1'b1;
        if (id_uses_rt && rt != 0) reads5[rt] = 1'b1;
        ex_hit  = RegWriteEn_IDEX  && reads5.exists(int'(writeRegister_IDEX));
        mem_hit = RegWriteEn_EXMEM && reads5.exists(int'(writeRegister_EXMEM));
        if (ex_hit && MemRead_IDEX) return id_is_branch ? 2 : 1;
        if (id_is_branch && ex_hit) return 1;
        if (id_is_branch && mem_hit && MemRead_EXMEM) return 1;
        return 0;
    endfunction

    function automatic exp_t model_out();
        exp_t e = '0;
        if (!rst_n) return e;
        e.bsy = (m_rem > 0);
        if (ext_hold) begin
            e.hold = 1'b1;
        end else if (m_rem > 0 || model_need() > 0) begin
            e.hold = 1'b1;
            e.bub  = 1'b1;
        end else if (id_valid && id_is_branch && branch_taken) begin
            e.fl = 1'b1;
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        if (!rst_n) begin
            m_rem = 0; m_sc = 0; m_fc = 0;
        end else if (!ext_hold) begin
            e = model_out();
            if (m_rem > 0) m_rem = m_rem - 1;
            else if (model_need() > 0) m_rem = model_need() - 1;
            if (e.bub && m_sc < SAT) m_sc = m_sc + 1;
            if (e.fl && m_fc < SAT) m_fc = m_fc + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        e = model_out();
        chk("stall_PC",     int'(stall_PC),     int'(e.hold));
        chk("stall_IFID",   int'(stall_IFID),   int'(e.hold));
        chk("bubble_IDEX",  int'(bubble_IDEX),  int'(e.bub));
        chk("flush_IFID",   int'(flush_IFID),   int'(e.fl));
        chk("busy",         int'(busy),         int'(e.bsy));
        chk("stall_cycles", int'(stall_cycles), m_sc);
        chk("flush_count",  int'(flush_count),  m_fc);
        $display("t=%0t stall=%0b bub=%0b flush=%0b busy=%0b sc=%0d fc=%0d",
                 $time, stall_PC, bubble_IDEX, flush_IFID, busy, stall_cycles, flush_count);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        id_valid = 1'b0; id_is_branch = 1'b0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        rs = 5'd0; rt = 5'd0;
        RegWriteEn_IDEX = 1'b0; MemRead_IDEX = 1'b0; writeRegister_IDEX = 5'd0;
        RegWriteEn_EXMEM = 1'b0; MemRead_EXMEM = 1'b0; writeRegister_EXMEM = 5'd0;
        branch_taken = 1'b0; ext_hold = 1'b0;
    endtask

    task automatic load_branch_7();
        clr();
        id_valid = 1'b1; id_is_branch = 1'b1; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
        rs = 5'd2; rt = 5'd7;
        RegWriteEn_IDEX = 1'b1; MemRead_IDEX = 1'b1; writeRegister_IDEX = 5'd7;
    endtask

    initial begin
        rst_n = 1'b0;
        load_branch_7();
        #1;
        chk("reset_stall_PC", int'(stall_PC), 0);
        chk("reset_bubble", int'(bubble_IDEX), 0);
        step(); step();
        chk("reset_stall_cycles", int'(stall_cycles), 0);
        chk("reset_busy", int'(busy), 0);
        clr();
        rst_n = 1'b1;
        step();

        // Load-use into ALU op: one stall cycle
        clr();
        id_valid = 1'b1; id_uses_rs = 1'b1; rs = 5'd5;
        RegWriteEn_IDEX = 1'b1; MemRead_IDEX = 1'b1; writeRegister_IDEX = 5'd5;
        #1;
        chk("lu_stall", int'(stall_PC), 1);
        chk("lu_busy", int'(busy), 0);
        step();
        clr();
        id_valid = 1'b1; id_uses_rs = 1'b1; rs = 5'd5;
        RegWriteEn_EXMEM = 1'b1; MemRead_EXMEM = 1'b1; writeRegister_EXMEM = 5'd5;
        #1;
        chk("lu_released", int'(stall_PC), 0);
        chk("lu_stall_cycles", int'(stall_cycles), 1);
        step();

        // Load feeding a branch: RUN then STALL
        load_branch_7();
        step();
        chk("lb_busy_2nd", int'(busy), 1);
        chk("lb_bubble_2nd", int'(bubble_IDEX), 1);
        step();
        clr();
        id_valid = 1'b1;
        #1;
        chk("lb_busy_done", int'(busy), 0);
        chk("lb_stall_cycles", int'(stall_cycles), 3);
        step();

        // ALU result feeding a taken branch: one stall then a flush
        clr();
        id_valid = 1'b1; id_is_branch = 1'b1; id_uses_rs = 1'b1; rs = 5'd3;
        RegWriteEn_IDEX = 1'b1; writeRegister_IDEX = 5'd3; branch_taken = 1'b1;
        #1;
        chk("ba_flush_suppressed", int'(flush_IFID), 0);
        step();
        RegWriteEn_IDEX = 1'b0; writeRegister_IDEX = 5'd0;
        RegWriteEn_EXMEM = 1'b1; writeRegister_EXMEM = 5'd3;
        #1;
        chk("ba_flush", int'(flush_IFID), 1);
        step();
        clr();
        chk("ba_flush_count", int'(flush_count), 1);
        chk("ba_stall_cycles", int'(stall_cycles), 4);
        step();

        // Load to $0 never stalls
        clr();
        id_valid = 1'b1; id_uses_rs = 1'b1; rs = 5'd0;
        RegWriteEn_IDEX = 1'b1; MemRead_IDEX = 1'b1; writeRegister_IDEX = 5'd0;
        #1;
        chk("zero_no_stall", int'(stall_PC), 0);
        step();

        // ext_hold freezes a pending STALL cycle
        load_branch_7();
        step();
        ext_hold = 1'b1;
        repeat (3) step();
        chk("hold_busy", int'(busy), 1);
        chk("hold_bubble", int'(bubble_IDEX), 0);
        chk("hold_frozen_sc", int'(stall_cycles), 5);
        ext_hold = 1'b0;
        #1;
        chk("hold_resume_bubble", int'(bubble_IDEX), 1);
        step();
        clr();
        id_valid = 1'b1;
        #1;
        chk("hold_after_busy", int'(busy), 0);
        chk("hold_after_sc", int'(stall_cycles), 6);
        step();

        // Reset in the middle of STALL
        load_branch_7();
        step();
        chk("mid_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", int'(stall_PC), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_sc", int'(stall_cycles), 0);
        step();
        clr();
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", int'(busy), 0);

        // Saturation: 20 consecutive load-use stalls
        clr();
        id_valid = 1'b1; id_uses_rt = 1'b1; rt = 5'd9;
        RegWriteEn_IDEX = 1'b1; MemRead_IDEX = 1'b1; writeRegister_IDEX = 5'd9;
        repeat (20) step();
        chk("sat_sc", int'(stall_cycles), 15);
        repeat (3) step();
        chk("sat_sc_hold", int'(stall_cycles), 15);
        chk("sat_fc", int'(flush_count), 0);
        clr();
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
